// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: key event record,
// frame FSM encoding, protocol prefixes and calculator scan codes.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    localparam int         FRAME_BITS = 11;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    localparam logic [7:0] KEY_0      = 8'h70;
    localparam logic [7:0] KEY_1      = 8'h69;
    localparam logic [7:0] KEY_2      = 8'h72;
    localparam logic [7:0] KEY_3      = 8'h7A;
    localparam logic [7:0] KEY_4      = 8'h6B;
    localparam logic [7:0] KEY_5      = 8'h73;
    localparam logic [7:0] KEY_6      = 8'h74;
    localparam logic [7:0] KEY_7      = 8'h6C;
    localparam logic [7:0] KEY_8      = 8'h75;
    localparam logic [7:0] KEY_9      = 8'h7D;
    localparam logic [7:0] KEY_PLUS   = 8'h79;
    localparam logic [7:0] KEY_MINUS  = 8'h7B;
    localparam logic [7:0] KEY_MUL    = 8'h7C;
    localparam logic [7:0] KEY_DIV    = 8'h4A;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_ESC    = 8'h76;

    // Frame layout after LSB-first shifting: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events with a registered head, valid/ready pop and
// a sticky overflow flag for pushes that arrive while full without a pop.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  key_event_t               i_data,
    input  logic                     i_pop,
    output key_event_t               o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    key_event_t          r_mem [DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    key_event_t          r_head;
    logic                r_valid;
    logic                r_overflow;

    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic [PW-1:0]       w_rd_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    key_event_t          w_head_nxt;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = i_pop && r_valid;
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign w_rd_nxt  = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    // Next occupancy and next head; a push landing on the next read slot bypasses the array.
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_cnt_nxt = r_count + CW'(1);
            2'b01:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
        if (w_push_ok && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = i_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_count <= w_cnt_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_cnt_nxt != CW'(0));
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = r_head;
    assign o_valid    = r_valid;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronise, tick-sample and filter the bus, deframe
// 11-bit packets, fold E0/F0 prefixes into flags and queue key events.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int FILTER_LEN    = 4,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_release,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_filt_clk;
    logic [FLT_W-1:0] r_flt_cnt;
    frame_state_t     r_state;
    frame_state_t     w_state_nxt;
    logic [10:0]      r_shift;
    logic [3:0]       r_bit_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_ext_flag;
    logic             r_rel_flag;
    logic             r_frame_err;

    logic             w_tick;
    logic             w_clk_s;
    logic             w_fall;
    logic             w_timeout;
    logic             w_push;
    logic             w_err;
    logic             w_set_ext;
    logic             w_set_rel;
    logic             w_clr_flags;
    key_event_t       w_evt;
    key_event_t       w_head;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DATA};
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_tick  = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    // Sample-tick divider.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN disagreeing ticks in a row.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_filt_clk <= 1'b1;
            r_flt_cnt  <= '0;
        end else if (w_tick) begin
            if (w_clk_s != r_filt_clk) begin
                if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                    r_filt_clk <= w_clk_s;
                    r_flt_cnt  <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + FLT_W'(1);
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    assign w_fall    = w_tick && r_filt_clk && !w_clk_s && (r_flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign w_timeout = (r_state == ST_SHIFT) && w_tick && !w_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    // Frame FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next state; bit count 10 plus this edge completes the 11-bit frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nxt = ST_SHIFT;
                else        w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_fall && (r_bit_cnt == 4'd10)) w_state_nxt = ST_CHECK;
                else if (w_timeout)                 w_state_nxt = ST_IDLE;
                else                                w_state_nxt = ST_SHIFT;
            end
            ST_CHECK: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame FSM outputs: error strobe, prefix flag control and FIFO push.
    always_comb begin
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_set_ext   = 1'b0;
        w_set_rel   = 1'b0;
        w_clr_flags = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                if (w_timeout) begin
                    w_err       = 1'b1;
                    w_clr_flags = 1'b1;
                end else begin
                    w_err = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!frame_ok(r_shift)) begin
                    w_err       = 1'b1;
                    w_clr_flags = 1'b1;
                end else if (r_shift[8:1] == PS2_EXT) begin
                    w_set_ext = 1'b1;
                end else if (r_shift[8:1] == PS2_BRK) begin
                    w_set_rel = 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_clr_flags = 1'b1;
                end
            end
            default: w_err = 1'b0;
        endcase
    end

    // Deframing datapath: LSB-first shift, bit count and inter-bit timeout.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift   <= '0;
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= '0;
        end else if (w_fall && ((r_state == ST_IDLE) || (r_state == ST_SHIFT))) begin
            r_shift   <= {r_dat_sync[1], r_shift[10:1]};
            r_bit_cnt <= (r_state == ST_IDLE) ? 4'd1 : (r_bit_cnt + 4'd1);
            r_to_cnt  <= '0;
        end else if ((r_state == ST_SHIFT) && w_tick) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else if (r_state != ST_SHIFT) begin
            r_to_cnt <= '0;
        end
    end

    // Prefix flags and registered error pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ext_flag  <= 1'b0;
            r_rel_flag  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_clr_flags) begin
                r_ext_flag <= 1'b0;
                r_rel_flag <= 1'b0;
            end else begin
                if (w_set_ext) r_ext_flag <= 1'b1;
                if (w_set_rel) r_rel_flag <= 1'b1;
            end
        end
    end

    assign w_evt = '{ext: r_ext_flag, rel: r_rel_flag, code: r_shift[8:1]};

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_push     (w_push),
        .i_data     (w_evt),
        .i_pop      (key_ready),
        .o_head     (w_head),
        .o_valid    (key_valid),
        .o_count    (fifo_count),
        .o_overflow (overflow)
    );

    assign key_code    = w_head.code;
    assign key_ext     = w_head.ext;
    assign key_release = w_head.rel;
    assign frame_err   = r_frame_err;

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Parametrised PS/2 keyboard receiver and scan-code decoder for the calculator front end. Supersedes the fixed-divider, bare-codeword keyboard front end.
- Synchronises and debounces PS2_CLK/PS2_DATA and deframes 11-bit packets with full start/parity/stop checking and an inter-bit timeout.
- Folds E0 (extended) and F0 (break) prefixes into flags, then buffers completed key events in a small FIFO with a valid/ready output handshake.
- Feeds the key-to-token mapper and the seven-segment display path.

Parameters:
- CLK_DIV, 50, sample-tick period in CLK cycles (≥2).
- FILTER_LEN, 4, consecutive identical ticks required before filtered PS2_CLK changes (≥1).
- TIMEOUT_TICKS, 4000, ticks without a falling edge before a partial frame is abandoned.
- FIFO_DEPTH, 4, key-event buffer entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PS2_CLK  in  1  keyboard clock, asynchronous
- PS2_DATA  in  1  keyboard data, asynchronous
- key_code  out  8  scan code at FIFO head
- key_ext  out  1  head event was preceded by E0
- key_release  out  1  head event was preceded by F0
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head this cycle
- frame_err  out  1  one-cycle pulse on rejected or timed-out frame
- overflow  out  1  sticky; event dropped because FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset: all state async-cleared on RST_N low. Outputs 0: key_code, key_ext, key_release, key_valid, frame_err, overflow, fifo_count. Synchroniser and filter reset to 1 (bus idle). FSM goes to IDLE.
- Synchronisation: 2-flop synchroniser on each PS/2 input.
- Tick generator: counter 0..CLK_DIV-1. tick is high for one CLK when the counter wraps. All frame logic advances only on tick.
- Filter: the filtered clock takes the synchronised level after FILTER_LEN consecutive equal ticks. Falling edge = filtered clock goes 1→0. Data is sampled from synchronised PS2_DATA on that tick.
- Frame FSM states IDLE, SHIFT, CHECK:
  - IDLE → SHIFT on a falling edge. That first bit is the start bit; bit count = 1.
  - SHIFT: each falling edge shifts data in LSB first and increments the count. At count 11 → CHECK.
  - SHIFT: timeout counter clears on every falling edge and increments each tick otherwise. At TIMEOUT_TICKS → IDLE, frame_err pulse, prefix flags cleared.
  - CHECK (one CLK): valid iff start=0, stop=1, and XOR(data, parity)=1 (odd parity). Invalid → frame_err pulse, prefix flags cleared, no push. Then → IDLE.
- Decode of a valid byte:
  - 0xE0 sets ext_flag; no push.
  - 0xF0 sets rel_flag; no push.
  - Any other byte pushes {ext_flag, rel_flag, byte} and clears both flags.
- FIFO and handshake:
  - Pop when key_valid && key_ready. Head fields are registered and valid whenever key_valid=1.
  - Pushed event is visible at the outputs the CLK after CHECK (latency 1 from CHECK).
  - Push while full and no pop: event dropped, overflow set until reset.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: not possible, since head is invalid.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: partial frame and flags discarded. Next packet decodes normally.

Decomposition:
- Package ps2_pkg:
  - key_event_t struct {ext, rel, code[7:0]}.
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Calculator scan-code constants: digits 70,69,72,7A,6B,73,74,6C,75,7D; + 79; - 7B; * 7C; / 4A; Enter 5A; Esc 76.
- One sub-module: ps2_event_fifo (parametrised sync FIFO of key_event_t).

Test Plan (CLK_DIV=4, FILTER_LEN=2, TIMEOUT_TICKS=64 for simulation):
- Frame 0x70 (bits 0,0,0,0,0,1,1,1,0, parity 0, stop 1) → one event: key_code=0x70, ext=0, rel=0, key_valid=1, fifo_count=1. Pop with key_ready → key_valid=0.
- Frames E0,75 then E0,F0,75 → two events: {ext=1, rel=0, 0x75}, then {ext=1, rel=1, 0x75}. No events for the prefixes.
- Frame 0x5A with parity bit inverted → frame_err one-cycle pulse, fifo_count stays 0. A following valid F0,5A → {ext=0, rel=1, 0x5A}, proving flags were cleared.
- Five bits of a frame, then bus idle for 70 ticks → frame_err pulse, FSM in IDLE. Next full frame 0x79 decodes correctly.
- key_ready=0, send 0x69,0x72,0x7A,0x6B,0x73 → fifo_count=4, overflow=1, heads pop in order 69,72,7A,6B. 0x73 is absent.
- RST_N low mid-frame for 3 CLKs → all outputs 0. A following 0x76 frame yields key_code=0x76.
